// File: rtl/multi_cs_bus_ctrl.sv
// Multiplexed-bus address latch, region decoder and chip-select/wait-state controller.
// All outputs registered; CS_N valid one cycle after ALE falls, READY held low for the region's wait states.
module multi_cs_bus_ctrl #(
  parameter int ADDR_W = 20,
  parameter int NREG   = 4,
  parameter int WAIT_W = 3,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NREG-1:0]        REG_IO   = 4'b1100,
  parameter logic [NREG*WAIT_W-1:0] REG_WAIT = {3'd2, 3'd1, 3'd0, 3'd0}
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] A_IN,
  output logic [ADDR_W-1:0] Address,
  output logic [NREG-1:0]   CS_N,
  output logic              READY,
  output logic              BUS_ERR
);

  typedef enum logic [1:0] {IDLE, LATCH, ACTIVE, WAITING} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [NREG-1:0]     cs_n_q, cs_n_d;
  logic                ready_q, ready_d;
  logic                bus_err_q, bus_err_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                seen_q, seen_d;
  logic [NREG-1:0]     hit, win;
  logic [WAIT_W-1:0]   win_wait;
  logic                strobe, both;

  assign strobe = ~RD | ~WR;
  assign both   = ~RD & ~WR;

  // Lowest-index hit wins: isolate the least significant set bit.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NREG; k++) begin
      hit[k] = ((addr_q & REG_MASK[k*ADDR_W +: ADDR_W]) ==
                (REG_BASE[k*ADDR_W +: ADDR_W] & REG_MASK[k*ADDR_W +: ADDR_W])) &&
               (IOM == REG_IO[k]);
    end
    win      = hit & (~hit + NREG'(1));
    win_wait = '0;
    for (int k = 0; k < NREG; k++) begin
      if (win[k]) win_wait = win_wait | REG_WAIT[k*WAIT_W +: WAIT_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    ready_d   = ready_q;
    bus_err_d = 1'b0;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    case (state_q)
      IDLE: begin
        if (ALE) state_d = LATCH;
      end
      LATCH: begin
        if (!ALE) begin
          cs_n_d    = ~win;
          cnt_d     = win_wait;
          ready_d   = 1'b1;
          seen_d    = 1'b0;
          bus_err_d = (hit == '0);
          state_d   = ACTIVE;
        end
      end
      default: begin
        if (ALE || both || (!strobe && seen_q)) begin
          cs_n_d    = '1;
          ready_d   = 1'b1;
          cnt_d     = '0;
          seen_d    = 1'b0;
          bus_err_d = !ALE && both;
          state_d   = ALE ? LATCH : IDLE;
        end else if (strobe) begin
          seen_d = 1'b1;
          if (state_q == ACTIVE) begin
            if (cnt_q != '0) begin
              ready_d = 1'b0;
              state_d = WAITING;
            end
          end else if (cnt_q != '0) begin
            // READY rises on the same edge the count lands on zero.
            cnt_d   = cnt_q - WAIT_W'(1);
            ready_d = (cnt_q == WAIT_W'(1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cs_n_q    <= '1;
      ready_q   <= 1'b1;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (ALE) addr_q <= A_IN;
      cs_n_q    <= cs_n_d;
      ready_q   <= ready_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
    end
  end

  assign Address = addr_q;
  assign CS_N    = cs_n_q;
  assign READY   = ready_q;
  assign BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_multi_cs_bus_ctrl.sv
// Bench for multi_cs_bus_ctrl: directed bus cycles plus randomized cycles scored against a
// transaction-level model of the region table and wait-state timing.
module tb_multi_cs_bus_ctrl;

  logic        CLK, RESET, ALE, IOM, RD, WR;
  logic [19:0] A_IN, Address;
  logic [3:0]  CS_N;
  logic        READY, BUS_ERR;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [19:0] M_BASE [4] = '{20'h00000, 20'h80000, 20'h0FF00, 20'h01C00};
  localparam logic [19:0] M_MASK [4] = '{20'h80000, 20'h80000, 20'h0FFF0, 20'h0FE00};
  localparam logic        M_IO   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam int          M_WAIT [4] = '{0, 0, 1, 2};

  multi_cs_bus_ctrl dut (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
    .A_IN(A_IN), .Address(Address), .CS_N(CS_N), .READY(READY), .BUS_ERR(BUS_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_region(input logic [19:0] a, input logic iom);
    for (int k = 0; k < 4; k++)
      if (((a & M_MASK[k]) == (M_BASE[k] & M_MASK[k])) && (iom == M_IO[k])) return k;
    return -1;
  endfunction

  function automatic logic [3:0] model_cs(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return (idx < 0) ? 4'hF : ~(one << idx);
  endfunction

  // Inputs change at negedge; outputs are sampled at negedge before new inputs are applied.
  task automatic latch_and_decode(input logic [19:0] a, input logic iom, input logic [3:0] exp_cs);
    ALE = 1'b1; A_IN = a; IOM = iom;
    @(negedge CLK);
    chk("addr_latch", Address, a);
    chk("cs_during_latch", CS_N, 4'hF);
    ALE = 1'b0; A_IN = 20'($urandom);
    @(negedge CLK);
    chk("addr_hold", Address, a);
    chk("cs_decode", CS_N, exp_cs);
    chk("err_decode", BUS_ERR, (exp_cs == 4'hF));
    chk("rdy_decode", READY, 1'b1);
  endtask

  task automatic strobe_phase(input logic use_wr, input logic [3:0] exp_cs, input int exp_w,
                              input int len);
    if (use_wr) WR = 1'b0; else RD = 1'b0;
    for (int i = 1; i <= len; i++) begin
      @(negedge CLK);
      chk("rdy_strobe", READY, (i <= exp_w) ? 1'b0 : 1'b1);
      chk("cs_strobe", CS_N, exp_cs);
      chk("err_strobe", BUS_ERR, 1'b0);
    end
    RD = 1'b1; WR = 1'b1;
    @(negedge CLK);
    chk("cs_release", CS_N, 4'hF);
    chk("rdy_release", READY, 1'b1);
  endtask

  task automatic bus_txn(input logic [19:0] a, input logic iom, input logic use_wr,
                         input logic [3:0] exp_cs, input int exp_w, input int len);
    latch_and_decode(a, iom, exp_cs);
    strobe_phase(use_wr, exp_cs, exp_w, len);
  endtask

  initial begin
    RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1; A_IN = 20'h00000;
    #1;
    chk("rst_addr", Address, 20'h0);
    chk("rst_cs", CS_N, 4'hF);
    chk("rst_rdy", READY, 1'b1);
    chk("rst_err", BUS_ERR, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Directed cycles from the region table.
    bus_txn(20'h12345, 1'b0, 1'b0, 4'b1110, 0, 3);
    bus_txn(20'h0FF03, 1'b1, 1'b1, 4'b1011, 1, 3);
    bus_txn(20'h01C10, 1'b1, 1'b0, 4'b0111, 2, 4);
    bus_txn(20'h00000, 1'b1, 1'b0, 4'b1111, 0, 2);
    bus_txn(20'h80010, 1'b0, 1'b1, 4'b1101, 0, 2);

    // Both strobes low together.
    latch_and_decode(20'h0FF03, 1'b1, 4'b1011);
    RD = 1'b0; WR = 1'b0;
    @(negedge CLK);
    chk("both_err", BUS_ERR, 1'b1);
    chk("both_cs", CS_N, 4'hF);
    chk("both_rdy", READY, 1'b1);
    RD = 1'b1; WR = 1'b1;
    @(negedge CLK);
    chk("both_err_pulse", BUS_ERR, 1'b0);
    chk("both_cs_idle", CS_N, 4'hF);

    // ALE re-asserted while waiting aborts and relatches.
    latch_and_decode(20'h01C10, 1'b1, 4'b0111);
    RD = 1'b0;
    @(negedge CLK);
    chk("abort_rdy_low", READY, 1'b0);
    RD = 1'b1; ALE = 1'b1; A_IN = 20'h12345; IOM = 1'b0;
    @(negedge CLK);
    chk("abort_cs", CS_N, 4'hF);
    chk("abort_rdy", READY, 1'b1);
    chk("abort_addr", Address, 20'h12345);
    ALE = 1'b0;
    @(negedge CLK);
    chk("abort_new_cs", CS_N, 4'b1110);
    strobe_phase(1'b0, 4'b1110, 0, 2);

    // Reset in the middle of a waiting cycle releases outputs without a clock edge.
    latch_and_decode(20'h01C10, 1'b1, 4'b0111);
    RD = 1'b0;
    @(negedge CLK);
    chk("prerst_rdy", READY, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_cs", CS_N, 4'hF);
    chk("midrst_rdy", READY, 1'b1);
    chk("midrst_addr", Address, 20'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("postrst_cs", CS_N, 4'hF);
      chk("postrst_rdy", READY, 1'b1);
    end
    RD = 1'b1;
    @(negedge CLK);

    // Randomized cycles scored against the region model.
    for (int t = 0; t < 60; t++) begin
      logic [19:0] a;
      logic        iom;
      int          idx, w, sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 20'($urandom);
        1:       a = 20'h0FF00 | 20'($urandom_range(0, 15));
        2:       a = 20'h01C00 | 20'($urandom_range(0, 511));
        default: a = 20'h80000 | 20'($urandom);
      endcase
      iom = 1'($urandom);
      idx = model_region(a, iom);
      w   = (idx < 0) ? 0 : M_WAIT[idx];
      bus_txn(a, iom, 1'($urandom), model_cs(idx), w, w + 1 + $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_cs_bus_ctrl.md
MULTI_CS_BUS_CTRL -- requirements
Module: multi_cs_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning the latched bus address width.
REQ-002 SHALL have parameter NREG, default 4, meaning the number of decoded regions and chip selects.
REQ-003 SHALL have parameter WAIT_W, default 3, meaning the wait-state counter width.
REQ-004 SHALL have parameter REG_BASE, [NREG*ADDR_W], default {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000}, meaning the per-region base addresses.
REQ-005 SHALL have parameter REG_MASK, [NREG*ADDR_W], default {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000}, meaning the per-region compare masks.
REQ-006 SHALL have parameter REG_IO, [NREG], default 4'b1100, meaning the region is an I/O region (1) or a memory region (0).
REQ-007 SHALL have parameter REG_WAIT, [NREG*WAIT_W], default {3'd2, 3'd1, 3'd0, 3'd0}, meaning the wait states per region.
REQ-008 SHALL have port CLK, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-009 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port ALE, input, 1 bit: address latch enable from the CPU.
REQ-011 SHALL have port IOM, input, 1 bit: 1 = I/O cycle, 0 = memory cycle.
REQ-012 SHALL have port RD, input, 1 bit: active-low read strobe.
REQ-013 SHALL have port WR, input, 1 bit: active-low write strobe.
REQ-014 SHALL have port A_IN, input, ADDR_W bits: the multiplexed address, {A, AD}.
REQ-015 SHALL have port Address, output, ADDR_W bits: the latched address.
REQ-016 SHALL have port CS_N, output, NREG bits: active-low chip selects.
REQ-017 SHALL have port READY, output, 1 bit: 1 = CPU may complete the cycle.
REQ-018 SHALL have port BUS_ERR, output, 1 bit: one-cycle pulse on a decode miss or protocol error.

Function
REQ-019 Address SHALL load A_IN on every rising edge where ALE=1 and hold otherwise.
REQ-020 Region k SHALL hit when (Address & MASK[k]) == (BASE[k] & MASK[k]) and IOM == REG_IO[k].
REQ-021 On multiple hits, the lowest index SHALL win, so at most one CS_N bit is 0.
REQ-022 The FSM SHALL have states IDLE, LATCH, ACTIVE and WAITING.
REQ-023 In IDLE with ALE sampled 1, the FSM SHALL go to LATCH.
REQ-024 In LATCH with ALE sampled 0, the FSM SHALL decode Address/IOM, register CS_N[k]=0 for the winning region, load the counter with REG_WAIT[k], and go to ACTIVE.
- CS_N is therefore valid 1 cycle after the ALE fall.
REQ-025 On a decode miss in LATCH, CS_N SHALL stay all-1, BUS_ERR SHALL pulse 1 cycle, the counter SHALL load 0, and the FSM SHALL go to ACTIVE.
REQ-026 In ACTIVE, on the first edge sampling RD=0 or WR=0 with counter>0, READY SHALL go 0 and the FSM SHALL go to WAITING.
- With counter==0, READY SHALL remain 1.
REQ-027 In WAITING, the counter SHALL decrement each cycle; READY SHALL return to 1 on the edge the counter reaches 0.
- Total READY-low time SHALL be exactly REG_WAIT[k] cycles.
REQ-028 From ACTIVE/WAITING, when the strobe is sampled high after having been low, CS_N SHALL go all-1, READY SHALL go 1, and the FSM SHALL go to IDLE.
REQ-029 If ALE is sampled 1 in ACTIVE/WAITING, the cycle SHALL abort: CS_N all-1, READY 1, counter cleared, FSM to LATCH.
REQ-030 If RD=0 and WR=0 are sampled together, BUS_ERR SHALL pulse, CS_N SHALL go all-1, READY SHALL go 1, and the FSM SHALL go to IDLE.
REQ-031 A REG_WAIT value of 0 SHALL never drop READY.
- The counter SHALL not underflow or wrap.
REQ-032 All outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-033 RESET=1 SHALL immediately force Address=0, CS_N all-1, READY=1, BUS_ERR=0, counter=0 and state IDLE, regardless of CLK.
REQ-034 Reset asserted mid-cycle (WAITING) SHALL release CS_N and READY at once; after deassertion, the block SHALL wait for a new ALE.

Verification
REQ-035 Memory read: ALE pulse with A_IN=20'h12345, IOM=0, then RD low 3 cycles -> CS_N=4'b1110, READY stays 1, CS_N=4'b1111 after RD rises.
REQ-036 I/O write: A_IN=20'h0FF03, IOM=1, WR low -> CS_N=4'b1011, READY low exactly 1 cycle.
REQ-037 I/O read: A_IN=20'h01C10, IOM=1, RD low -> CS_N=4'b0111, READY low exactly 2 cycles.
REQ-038 Miss: A_IN=20'h00000, IOM=1 -> CS_N=4'b1111, BUS_ERR high 1 cycle, READY stays 1.
REQ-039 Error and abort: RD and WR low together -> BUS_ERR pulse, FSM to IDLE; ALE re-asserted during WAITING -> CS_N released, new address latched.
REQ-040 Reset during WAITING for region 3 -> CS_N=4'b1111 and READY=1 in the same cycle as RESET rises.
